// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receive buffer. It takes one word per data_ready/data_ack
//            handshake and presents it on a first-word-fall-through read port.
//            Define UART_RX_OVERRUN_CNT_EN to build the saturating overrun counter.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DBITS      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_100MHz,
   input  logic                  reset_n,
   input  logic                  rx_data_ready,
   input  logic [DBITS-1:0]      rx_data,
   output logic                  rx_data_ack,
   input  logic                  rd_en,
   output logic [DBITS-1:0]      rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  overrun_clr,
   output logic [7:0]            overrun_cnt
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    ack_q, ack_d;
   logic [DBITS-1:0]        mem_q [DEPTH];
   logic [DBITS-1:0]        mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    overrun_q, overrun_d;

   logic capture;
   logic wr_fire;
   logic drop;
   logic rd_fire;

   // Full and empty come from the occupancy before the edge, so a capture
   // while full is dropped even if a pop happens in the same cycle.
   assign full    = (count_q == COUNT_FULL);
   assign empty   = (count_q == '0);
   assign capture = (state_q == ST_IDLE) && rx_data_ready;
   assign wr_fire = capture && !full;
   assign drop    = capture && full;
   assign rd_fire = rd_en && !empty;

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_data_ready) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
            end
         end
         ST_ACK:  state_d = ST_WAIT;
         // Hold here until the receiver drops data_ready, so one word is never captured twice.
         ST_WAIT: begin
            if (!rx_data_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_fire) begin
         mem_d[wr_ptr_q] = rx_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (drop) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ack_q     <= 1'b0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef UART_RX_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   // A clear that coincides with a drop counts that drop, which leaves the counter at 1.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_clr) begin
         ovr_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop && (ovr_cnt_q != 8'hFF)) begin
         ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         ovr_cnt_q <= 8'd0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`else
   assign overrun_cnt = 8'd0;
`endif

   assign rx_data_ack = ack_q;
   assign rd_data     = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire
